// File: rtl/retire_trace_tx_pkg.sv
// Shared constants and types for the retire trace transmitter: frame length,
// record layout, default header byte and the frame byte selector.
package retire_trace_tx_pkg;

    localparam int         FRAME_LEN   = 10;
    localparam int         IDX_W       = 4;
    localparam logic [7:0] DEFAULT_HDR = 8'hA5;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } tx_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] wdata;
    } ret_rec_t;

    localparam int REC_W = $bits(ret_rec_t);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    // Byte 5 carries the write enable in bit 7 and rd in the low five bits.
    function automatic logic [7:0] field_byte5(input logic we, input logic [4:0] rd);
        return {we, 2'b00, rd};
    endfunction

    function automatic logic [7:0] frame_byte(input ret_rec_t rec,
                                              input logic [IDX_W-1:0] idx,
                                              input logic [7:0] hdr);
        case (idx)
            4'd0:    return hdr;
            4'd1:    return rec.pc[7:0];
            4'd2:    return rec.pc[15:8];
            4'd3:    return rec.pc[23:16];
            4'd4:    return rec.pc[31:24];
            4'd5:    return field_byte5(rec.we, rec.rd);
            4'd6:    return rec.wdata[7:0];
            4'd7:    return rec.wdata[15:8];
            4'd8:    return rec.wdata[23:16];
            4'd9:    return rec.wdata[31:24];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular record FIFO with extra-bit wrap-around pointers for full/empty and
// an occupancy counter running 0..DEPTH. A pop frees a slot for a same-cycle push.
module trace_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 70
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        din,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [AW:0]      count_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             do_push_s;
    logic             do_pop_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];
    assign count     = count_r;

    // Pointer and occupancy update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + ONE;
                2'b01:   count_r <= count_r - ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Record storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/retire_trace_tx.sv
// Retirement trace transmitter: buffers retired-instruction records and
// serializes each into a 10-byte frame. Define TRACE_OVF_CNT_EN for the drop counter.
module retire_trace_tx
    import retire_trace_tx_pkg::*;
#(
    parameter int         DEPTH = 4,
    parameter logic [7:0] HDR   = DEFAULT_HDR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ret_valid,
    input  logic [31:0] ret_pc,
    input  logic [4:0]  ret_rd,
    input  logic        ret_we,
    input  logic [31:0] ret_wdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic [15:0] ovf_cnt,
    output logic        busy
);
    localparam int CW = $clog2(DEPTH) + 1;

    tx_state_e        state_r;
    tx_state_e        state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    ret_rec_t         frame_r;
    ret_rec_t         frame_nxt_s;
    ret_rec_t         head_s;
    ret_rec_t         ret_rec_s;
    logic             tx_valid_r;
    logic             tx_valid_nxt_s;
    logic [7:0]       tx_data_r;
    logic [7:0]       tx_data_nxt_s;
    logic             push_s;
    logic             pop_s;
    logic             full_s;
    logic             empty_s;
    logic [CW-1:0]    count_s;

    assign ret_rec_s = '{pc: ret_pc, rd: ret_rd, we: ret_we, wdata: ret_wdata};
    assign push_s    = ret_valid && (!full_s || pop_s);

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (ret_rec_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Next-state logic; outputs are computed one cycle ahead and registered.
    always_comb begin
        state_nxt_s    = state_r;
        idx_nxt_s      = idx_r;
        frame_nxt_s    = frame_r;
        tx_valid_nxt_s = tx_valid_r;
        tx_data_nxt_s  = tx_data_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!empty_s) begin
                    pop_s          = 1'b1;
                    frame_nxt_s    = head_s;
                    idx_nxt_s      = '0;
                    state_nxt_s    = ST_SEND;
                    tx_valid_nxt_s = 1'b1;
                    tx_data_nxt_s  = frame_byte(head_s, 4'd0, HDR);
                end else begin
                    tx_valid_nxt_s = 1'b0;
                    tx_data_nxt_s  = 8'h00;
                end
            end
            ST_SEND: begin
                if (tx_ready && (idx_r == LAST_IDX)) begin
                    state_nxt_s    = ST_IDLE;
                    idx_nxt_s      = '0;
                    tx_valid_nxt_s = 1'b0;
                    tx_data_nxt_s  = 8'h00;
                end else if (tx_ready) begin
                    idx_nxt_s      = idx_r + 4'd1;
                    tx_data_nxt_s  = frame_byte(frame_r, idx_r + 4'd1, HDR);
                end else begin
                    tx_valid_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                idx_nxt_s      = '0;
                tx_valid_nxt_s = 1'b0;
                tx_data_nxt_s  = 8'h00;
            end
        endcase
    end

    // State, frame and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            idx_r      <= '0;
            frame_r    <= '0;
            tx_valid_r <= 1'b0;
            tx_data_r  <= 8'h00;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            frame_r    <= frame_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
        end
    end

    assign tx_valid = tx_valid_r;
    assign tx_data  = tx_data_r;
    assign busy     = (count_s != '0) || (state_r == ST_SEND);

`ifdef TRACE_OVF_CNT_EN
    logic [15:0] ovf_cnt_r;
    logic        drop_s;

    assign drop_s = ret_valid && !push_s;

    // Saturating count of records lost to a full FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_cnt_r <= 16'h0000;
        end else if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 16'h0001;
        end
    end

    assign ovf_cnt = ovf_cnt_r;
`else
    assign ovf_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_retire_trace_tx.sv
// Directed self-checking bench for retire_trace_tx (DEPTH=4, default header).
module tb_retire_trace_tx;
    localparam int         DEPTH = 4;
    localparam logic [7:0] HDR   = 8'hA5;
`ifdef TRACE_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        ret_valid;
    logic [31:0] ret_pc;
    logic [4:0]  ret_rd;
    logic        ret_we;
    logic [31:0] ret_wdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic [15:0] ovf_cnt;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int drops   = 0;

    logic [7:0]  exp_b [10];
    logic [31:0] r_pc  [8];
    logic [4:0]  r_rd  [8];
    logic        r_we  [8];
    logic [31:0] r_wd  [8];

    always #5 clk = ~clk;

    retire_trace_tx #(
        .DEPTH (DEPTH),
        .HDR   (HDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ret_valid (ret_valid),
        .ret_pc    (ret_pc),
        .ret_rd    (ret_rd),
        .ret_we    (ret_we),
        .ret_wdata (ret_wdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .ovf_cnt   (ovf_cnt),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] exp_ovf();
        if (!OVF_EN) return 32'd0;
        return (drops > 65535) ? 32'h0000_FFFF : 32'(drops);
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input int i);
        case (i)
            0:       return HDR;
            1:       return r_pc[k][7:0];
            2:       return r_pc[k][15:8];
            3:       return r_pc[k][23:16];
            4:       return r_pc[k][31:24];
            5:       return {r_we[k], 2'b00, r_rd[k]};
            6:       return r_wd[k][7:0];
            7:       return r_wd[k][15:8];
            8:       return r_wd[k][23:16];
            9:       return r_wd[k][31:24];
            default: return 8'h00;
        endcase
    endfunction

    task automatic push_raw(input logic [31:0] pc, input logic [4:0] rd,
                            input logic we, input logic [31:0] wd);
        ret_pc    = pc;
        ret_rd    = rd;
        ret_we    = we;
        ret_wdata = wd;
        ret_valid = 1'b1;
        step();
        ret_valid = 1'b0;
    endtask

    task automatic push_rec(input int k);
        push_raw(r_pc[k], r_rd[k], r_we[k], r_wd[k]);
    endtask

    // Expects byte 0 of a frame visible now; walks the whole frame out.
    task automatic run_bytes(input string tag, input int stall_at, input int stall_n);
        for (int i = 0; i < 10; i++) begin
            if (i == stall_at) begin
                tx_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_val($sformatf("%s_hold%0d_v", tag, s), 32'(tx_valid), 32'd1);
                    check_val($sformatf("%s_hold%0d_d", tag, s), 32'(tx_data), 32'(exp_b[i]));
                    step();
                end
            end
            tx_ready = 1'b1;
            check_val($sformatf("%s_b%0d_v", tag, i), 32'(tx_valid), 32'd1);
            check_val($sformatf("%s_b%0d", tag, i), 32'(tx_data), 32'(exp_b[i]));
            step();
        end
    endtask

    task automatic run_frame(input int k);
        for (int i = 0; i < 10; i++) exp_b[i] = exp_byte(k, i);
        run_bytes($sformatf("rec%0d", k), -1, 0);
    endtask

    task automatic gap();
        check_val("gap_idle", 32'(tx_valid), 32'd0);
        step();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            r_pc[i] = 32'h8000_0000 | (32'(i) << 8) | 32'h0000_0004;
            r_rd[i] = 5'(i + 1);
            r_we[i] = (i % 2) == 0;
            r_wd[i] = 32'hC0DE_0000 + 32'(i) * 32'h0011_0101;
        end
        reset     = 1'b1;
        ret_valid = 1'b0;
        ret_pc    = 32'h0;
        ret_rd    = 5'h0;
        ret_we    = 1'b0;
        ret_wdata = 32'h0;
        tx_ready  = 1'b1;

        #12;
        check_val("rst_valid", 32'(tx_valid), 32'd0);
        check_val("rst_data", 32'(tx_data), 32'h00);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ovf", 32'(ovf_cnt), 32'd0);
        step();
        reset = 1'b0;

        // Single record with the consumer always ready.
        push_raw(32'h0000_0010, 5'd5, 1'b1, 32'hDEAD_BEEF);
        check_val("lat_not_yet", 32'(tx_valid), 32'd0);
        check_val("lat_busy", 32'(busy), 32'd1);
        step();
        exp_b = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h85, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_bytes("single", -1, 0);
        check_val("single_end_v", 32'(tx_valid), 32'd0);
        check_val("single_end_busy", 32'(busy), 32'd0);

        // Three-cycle stall on byte 2.
        push_raw(32'h0000_0010, 5'd31, 1'b0, 32'h0102_0304);
        step();
        exp_b = '{8'hA5, 8'h10, 8'h00, 8'h00, 8'h00, 8'h1F, 8'h04, 8'h03, 8'h02, 8'h01};
        run_bytes("bp", 2, 3);
        check_val("bp_end_v", 32'(tx_valid), 32'd0);

        // Overflow: one frame stalled, six more pushes, four fit.
        tx_ready = 1'b0;
        for (int k = 0; k <= 6; k++) push_rec(k);
        drops += 2;
        check_val("ovf_cnt", 32'(ovf_cnt), exp_ovf());
        check_val("ovf_busy", 32'(busy), 32'd1);
        run_frame(0);
        for (int k = 1; k <= 4; k++) begin
            gap();
            run_frame(k);
        end
        gap();
        check_val("ovf_drained_v", 32'(tx_valid), 32'd0);
        check_val("ovf_drained_busy", 32'(busy), 32'd0);

        // Full FIFO: push in the cycle the next record is loaded.
        tx_ready = 1'b0;
        for (int k = 0; k <= 4; k++) push_rec(k);
        run_frame(0);
        check_val("fullpop_idle", 32'(tx_valid), 32'd0);
        check_val("fullpop_busy", 32'(busy), 32'd1);
        push_rec(5);
        check_val("fullpop_ovf", 32'(ovf_cnt), exp_ovf());
        run_frame(1);
        for (int k = 2; k <= 5; k++) begin
            gap();
            run_frame(k);
        end
        gap();
        check_val("fullpop_drained_v", 32'(tx_valid), 32'd0);
        check_val("fullpop_drained_busy", 32'(busy), 32'd0);

        // Reset while byte 4 is on the bus.
        tx_ready = 1'b1;
        push_rec(6);
        step();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("mid_b%0d", i), 32'(tx_data), 32'(exp_byte(6, i)));
            step();
        end
        check_val("mid_b4", 32'(tx_data), 32'(exp_byte(6, 4)));
        #2;
        reset     = 1'b1;
        ret_valid = 1'b1;
        #1;
        check_val("mid_rst_v", 32'(tx_valid), 32'd0);
        check_val("mid_rst_busy", 32'(busy), 32'd0);
        check_val("mid_rst_d", 32'(tx_data), 32'h00);
        step();
        step();
        check_val("mid_rst_ignore_busy", 32'(busy), 32'd0);
        ret_valid = 1'b0;
        reset     = 1'b0;
        drops     = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            check_val($sformatf("post_rst_v%0d", c), 32'(tx_valid), 32'd0);
        end
        check_val("post_rst_busy", 32'(busy), 32'd0);
        check_val("post_rst_ovf", 32'(ovf_cnt), 32'd0);

        // Sustained drops against a full FIFO.
        tx_ready = 1'b0;
        for (int k = 0; k <= 4; k++) push_rec(k);
        ret_pc    = r_pc[7];
        ret_rd    = r_rd[7];
        ret_we    = r_we[7];
        ret_wdata = r_wd[7];
        ret_valid = 1'b1;
`ifdef TRACE_OVF_CNT_EN
        repeat (65534) step();
        drops += 65534;
        check_val("sat_fffe", 32'(ovf_cnt), exp_ovf());
        repeat (3) step();
        drops += 3;
        check_val("sat_ffff", 32'(ovf_cnt), 32'h0000_FFFF);
`else
        repeat (10) step();
        drops += 10;
        check_val("nocnt_ovf", 32'(ovf_cnt), exp_ovf());
`endif
        ret_valid = 1'b0;
        check_val("drop_tail_v", 32'(tx_valid), 32'd1);
        check_val("drop_tail_d", 32'(tx_data), 32'(exp_byte(0, 0)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
